// File: rtl/divisibility_stream_pkg.sv
// Shared types and helpers for divisibility_stream_checker.
// The optional signed-frame mode is enabled with the SIGNED_FRAME_EN macro in the top.
package divisibility_stream_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_t;

    // Working width for mod_reduce; DIVISOR*2^B must fit, so B may be at most 55.
    localparam int unsigned MOD_W = 64;

    // Remainder width: enough bits for 0..N-1, never less than one bit.
    function automatic int unsigned calc_rem_w(input int unsigned n);
        return (n < 2) ? 1 : int'($clog2(n));
    endfunction

    // Step counter width: enough bits for 0..steps-1, never less than one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned steps);
        return (steps < 2) ? 1 : int'($clog2(steps));
    endfunction

    // Restoring reduction of x < n*2^b to x mod n by conditional subtraction of n*2^k.
    function automatic logic [MOD_W-1:0] mod_reduce(input logic [MOD_W-1:0] x,
                                                   input int unsigned n,
                                                   input int unsigned b);
        logic [MOD_W-1:0] acc;
        logic [MOD_W-1:0] sub;
        acc = x;
        sub = '0;
        for (int k = MOD_W - 1; k >= 0; k--) begin
            if (k < int'(b)) begin
                sub = MOD_W'(n) << k;
                if (acc >= sub) acc = acc - sub;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/divisibility_stream_checker_mod_step.sv
// Combinational residue step: r_next = (r * 2^B + chunk) mod DIVISOR.
module mod_step
    import divisibility_stream_pkg::*;
#(
    parameter int unsigned DIVISOR = 3,
    parameter int unsigned B       = 1,
    parameter int unsigned REM_W   = 2
) (
    input  logic [REM_W-1:0] i_r,
    input  logic [B-1:0]     i_chunk,
    output logic [REM_W-1:0] o_r_next
);
    localparam int unsigned OP_W = REM_W + B + 1;

    logic [OP_W-1:0] w_operand;

    // r < N, so the operand is below N*2^B and one restoring pass suffices
    assign w_operand = {1'b0, i_r, i_chunk};
    assign o_r_next  = REM_W'(mod_reduce(MOD_W'(w_operand), DIVISOR, B));

endmodule

// File: rtl/divisibility_stream_checker.sv
// Streaming mod-N checker: folds each DATA_W-bit word MSB-first into a residue,
// BITS_PER_CYCLE bits per clock, and reports remainder/divisibility per frame.
// Define SIGNED_FRAME_EN to treat frames as two's complement (sign = MSB of first word).
module divisibility_stream_checker
    import divisibility_stream_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned DIVISOR        = 3,
    parameter int unsigned BITS_PER_CYCLE = 1,
    localparam int unsigned REM_W         = calc_rem_w(DIVISOR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_divisible,
    output logic [REM_W-1:0]  m_remainder
);
    localparam int unsigned STEPS = DATA_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = calc_cnt_w(STEPS);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic [REM_W-1:0]  r_res;
    logic              r_s_ready;
    logic              r_m_valid;
    logic              r_div;
    logic [REM_W-1:0]  r_rem;
    logic [REM_W-1:0]  w_res_next;
    logic [REM_W-1:0]  w_final;
    logic              w_take;
    logic              w_done;

    assign w_take = s_valid && r_s_ready;
    assign w_done = (r_cnt == CNT_W'(STEPS - 1));

    mod_step #(
        .DIVISOR (DIVISOR),
        .B       (BITS_PER_CYCLE),
        .REM_W   (REM_W)
    ) u_step_r (
        .i_r      (r_res),
        .i_chunk  (r_shift[DATA_W-1 -: BITS_PER_CYCLE]),
        .o_r_next (w_res_next)
    );

`ifdef SIGNED_FRAME_EN
    logic [REM_W-1:0] r_p;
    logic [REM_W-1:0] w_p_next;
    logic             r_sign;
    logic             r_first;

    // p tracks 2^L mod N for the bits folded so far
    mod_step #(
        .DIVISOR (DIVISOR),
        .B       (BITS_PER_CYCLE),
        .REM_W   (REM_W)
    ) u_step_p (
        .i_r      (r_p),
        .i_chunk  ({BITS_PER_CYCLE{1'b0}}),
        .o_r_next (w_p_next)
    );

    // Negative frame: value = U - 2^L, so remainder = (r - p) mod N, wrapped into [0, N-1]
    always_comb begin
        w_final = w_res_next;
        if (r_sign) begin
            if (w_res_next >= w_p_next) begin
                w_final = w_res_next - w_p_next;
            end else begin
                w_final = REM_W'((REM_W + 1)'(DIVISOR) - (REM_W + 1)'(w_p_next)
                                 + (REM_W + 1)'(w_res_next));
            end
        end
    end

    // Capture sign on the first word and restart p at each frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p     <= REM_W'(1);
            r_sign  <= 1'b0;
            r_first <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take && r_first) begin
                        r_sign  <= s_data[DATA_W-1];
                        r_first <= 1'b0;
                    end
                end
                SHIFT: r_p <= w_p_next;
                RESULT: begin
                    if (m_ready) begin
                        r_p     <= REM_W'(1);
                        r_first <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign w_final = w_res_next;
`endif

    // Control FSM with shift register, step counter, residue and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_last    <= 1'b0;
            r_cnt     <= '0;
            r_res     <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_div     <= 1'b0;
            r_rem     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_shift   <= s_data;
                        r_last    <= s_last;
                        r_cnt     <= '0;
                        r_s_ready <= 1'b0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_res   <= w_res_next;
                    r_shift <= r_shift << BITS_PER_CYCLE;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_done) begin
                        if (r_last) begin
                            r_rem     <= w_final;
                            r_div     <= (w_final == '0);
                            r_m_valid <= 1'b1;
                            r_state   <= RESULT;
                        end else begin
                            r_s_ready <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end
                end
                RESULT: begin
                    if (m_ready) begin
                        r_res     <= '0;
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_s_ready <= 1'b1;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = r_s_ready;
    assign m_valid     = r_m_valid;
    assign m_divisible = r_div;
    assign m_remainder = r_rem;

endmodule

// File: tb/tb_divisibility_stream_checker.sv
// Bench for divisibility_stream_checker: two instances (N=3,B=1 and N=7,B=4, DATA_W=8),
// directed table, hand-written backpressure/reset sequences and random frames vs. a model.
// Expectations follow SIGNED_FRAME_EN when it is defined.
module tb_divisibility_stream_checker;

    localparam int DW = 8;
    localparam int N0 = 3;
    localparam int B0 = 1;
    localparam int N1 = 7;
    localparam int B1 = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid [2];
    logic       s_ready [2];
    logic [7:0] s_data  [2];
    logic       s_last  [2];
    logic       m_valid [2];
    logic       m_ready [2];
    logic       m_div   [2];
    logic [1:0] m_rem0;
    logic [2:0] m_rem1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    divisibility_stream_checker #(
        .DATA_W         (DW),
        .DIVISOR        (N0),
        .BITS_PER_CYCLE (B0)
    ) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid[0]),
        .s_ready     (s_ready[0]),
        .s_data      (s_data[0]),
        .s_last      (s_last[0]),
        .m_valid     (m_valid[0]),
        .m_ready     (m_ready[0]),
        .m_divisible (m_div[0]),
        .m_remainder (m_rem0)
    );

    divisibility_stream_checker #(
        .DATA_W         (DW),
        .DIVISOR        (N1),
        .BITS_PER_CYCLE (B1)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid[1]),
        .s_ready     (s_ready[1]),
        .s_data      (s_data[1]),
        .s_last      (s_last[1]),
        .m_valid     (m_valid[1]),
        .m_ready     (m_ready[1]),
        .m_divisible (m_div[1]),
        .m_remainder (m_rem1)
    );

    typedef struct packed {
        int          idx;
        int          nw;
        logic [31:0] words;  // word 0 in [31:24]
        int          rem;
        int          dv;
    } vec_t;

    function automatic vec_t mk(input int idx, input int nw, input logic [31:0] words,
                                input int rem, input int dv);
        vec_t v;
        v.idx = idx; v.nw = nw; v.words = words; v.rem = rem; v.dv = dv;
        return v;
    endfunction

    function automatic int get_rem(input int idx);
        return (idx == 0) ? int'(m_rem0) : int'(m_rem1);
    endfunction

    function automatic int divisor_of(input int idx);
        return (idx == 0) ? N0 : N1;
    endfunction

    function automatic int latency_of(input int idx);
        return (idx == 0) ? DW / B0 + 1 : DW / B1 + 1;
    endfunction

    // Reference: whole frame as an integer, reduced with plain arithmetic
    function automatic int model_rem(input int n, input int nw, input logic [7:0] w [4]);
        longint v;
        v = 0;
        for (int i = 0; i < nw; i++) v = v * 256 + longint'(w[i]);
`ifdef SIGNED_FRAME_EN
        if (w[0][7]) v = v - (longint'(1) << (8 * nw));
`endif
        v = v % longint'(n);
        if (v < 0) v = v + longint'(n);
        return int'(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and wait (bounded) for its handshake; ends 1 step after the taking edge
    task automatic send_word(input int idx, input logic [7:0] d, input logic last,
                             output int ok);
        int t;
        ok = 0;
        t = 0;
        s_valid[idx] = 1'b1;
        s_data[idx]  = d;
        s_last[idx]  = last;
        while (!s_ready[idx] && t < 100) begin
            tick();
            t++;
        end
        if (s_ready[idx]) begin
            tick();
            ok = 1;
        end
        s_valid[idx] = 1'b0;
        s_data[idx]  = 8'($urandom);
        s_last[idx]  = 1'($urandom);
    endtask

    // Send a frame, wait for the result, optionally stall, then accept it
    task automatic run_frame(input int idx, input int nw, input logic [7:0] w [4],
                             input int hold, output int acc, output int lat,
                             output int rem, output int dv);
        int t;
        int ok;
        acc = 0; lat = -1; rem = -1; dv = -1;
        for (int i = 0; i < nw; i++) begin
            send_word(idx, w[i], (i == nw - 1), ok);
            acc += ok;
        end
        t = 1;
        while (!m_valid[idx] && t < 200) begin
            tick();
            t++;
        end
        if (m_valid[idx]) begin
            lat = t;
            rem = get_rem(idx);
            dv  = int'(m_div[idx]);
            if (hold > 0) begin
                repeat (hold) tick();
                check("hold_valid", int'(m_valid[idx]), 1);
                check("hold_rem", get_rem(idx), rem);
            end
            m_ready[idx] = 1'b1;
            tick();
            m_ready[idx] = 1'b0;
        end
    endtask

    vec_t       tbl [10];
    logic [7:0] w [4];
    int         acc, lat, rem, dv, exp_rem, idx, nw, seen;

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = '0;
            s_last[i]  = 1'b0;
            m_ready[i] = 1'b0;
        end

        tbl[0] = mk(0, 1, 32'h15000000, 0, 1);  // 21
        tbl[1] = mk(0, 2, 32'h01000000, 1, 0);  // 256
        tbl[2] = mk(1, 1, 32'h64000000, 2, 0);  // 100
        tbl[3] = mk(0, 2, 32'h12340000, 1, 0);  // 4660
        tbl[4] = mk(1, 1, 32'h00000000, 0, 1);
`ifdef SIGNED_FRAME_EN
        tbl[5] = mk(1, 3, 32'hFFFFFF00, 6, 0);  // -1
        tbl[6] = mk(0, 1, 32'hFF000000, 2, 0);  // -1
        tbl[7] = mk(0, 1, 32'hFD000000, 0, 1);  // -3
        tbl[8] = mk(0, 1, 32'hFE000000, 1, 0);  // -2
        tbl[9] = mk(1, 2, 32'h80000000, 6, 0);  // -32768
`else
        tbl[5] = mk(1, 3, 32'hFFFFFF00, 0, 1);  // 16777215
        tbl[6] = mk(0, 1, 32'hFF000000, 0, 1);  // 255
        tbl[7] = mk(0, 1, 32'hFD000000, 1, 0);  // 253
        tbl[8] = mk(0, 1, 32'hFE000000, 2, 0);  // 254
        tbl[9] = mk(1, 2, 32'h80000000, 1, 0);  // 32768
`endif

        // Reset state
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_s_ready", int'(s_ready[i]), 1);
            check("rst_m_valid", int'(m_valid[i]), 0);
            check("rst_m_div", int'(m_div[i]), 0);
            check("rst_m_rem", get_rem(i), 0);
        end
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 4; i++) w[i] = tbl[v].words[31 - 8 * i -: 8];
            run_frame(tbl[v].idx, tbl[v].nw, w, 0, acc, lat, rem, dv);
            check($sformatf("tbl%0d_words", v), acc, tbl[v].nw);
            check($sformatf("tbl%0d_latency", v), lat, latency_of(tbl[v].idx));
            check($sformatf("tbl%0d_rem", v), rem, tbl[v].rem);
            check($sformatf("tbl%0d_div", v), dv, tbl[v].dv);
            check($sformatf("tbl%0d_released", v), int'(m_valid[tbl[v].idx]), 0);
            check($sformatf("tbl%0d_ready_again", v), int'(s_ready[tbl[v].idx]), 1);
        end

        // Backpressure: result held 5 clocks with a competing word offered
        send_word(0, 8'd10, 1'b1, acc);
        seen = 0;
        while (!m_valid[0] && seen < 50) begin
            tick();
            seen++;
        end
        check("bp_valid", int'(m_valid[0]), 1);
        s_valid[0] = 1'b1;
        s_data[0]  = 8'd5;
        s_last[0]  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_hold", int'(m_valid[0]), 1);
            check("bp_rem_hold", get_rem(0), 1);
            check("bp_div_hold", int'(m_div[0]), 0);
            check("bp_s_ready_low", int'(s_ready[0]), 0);
            tick();
        end
        m_ready[0] = 1'b1;
        tick();
        m_ready[0] = 1'b0;
        w[0] = 8'd5;
        run_frame(0, 1, w, 0, acc, lat, rem, dv);
        check("bp_next_words", acc, 1);
        check("bp_next_rem", rem, 2);
        check("bp_next_div", dv, 0);

        // Reset mid-frame after word 1 of 2
        send_word(0, 8'h01, 1'b0, acc);
        check("mid_word1_taken", acc, 1);
        tick();
        check("mid_shift_not_ready", int'(s_ready[0]), 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_s_ready", int'(s_ready[0]), 1);
        check("mid_rst_m_valid", int'(m_valid[0]), 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_valid[0]) seen++;
            tick();
        end
        check("mid_no_result", seen, 0);
        w[0] = 8'd6;
        run_frame(0, 1, w, 0, acc, lat, rem, dv);
        check("mid_next_rem", rem, 0);
        check("mid_next_div", dv, 1);

        // Random frames against the model
        for (int k = 0; k < 60; k++) begin
            idx = k % 2;
            nw  = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
            exp_rem = model_rem(divisor_of(idx), nw, w);
            run_frame(idx, nw, w, int'($urandom_range(0, 3)), acc, lat, rem, dv);
            check($sformatf("rand%0d_words", k), acc, nw);
            check($sformatf("rand%0d_rem", k), rem, exp_rem);
            check($sformatf("rand%0d_div", k), dv, (exp_rem == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
